// File: rtl/attn_pkg.sv
// Shared types and helpers for the attention weighted-sum stage.
// Holds the controller state encoding, default lane widths, the rounding
// bias used before the fixed-point shift, and the lane clamp helper.
package attn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } wsum_state_t;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_PROB_W = 16;

    // Half an LSB of the Q0.prob_w scale: adding it before the arithmetic
    // shift rounds half toward +inf.
    function automatic logic signed [63:0] round_bias(input int unsigned prob_w);
        return 64'sd1 <<< (prob_w - 1);
    endfunction

    // Clamp a sign-extended value into the signed data_w range.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] r,
                                                    input int unsigned       data_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (r > hi) begin
            return hi;
        end
        if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/wsum_lane.sv
// One value lane of the weighted sum: signed x unsigned MAC with
// clear/load/accumulate controls, plus round and width reduction of the
// final sum into a registered result.
// Config: ATTN_WSUM_SAT_EN clamps the reduced result and reports clamping;
// without it the result wraps and sat is held low.
module wsum_lane
    import attn_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PROB_W = DEF_PROB_W,
    parameter int unsigned ACC_W  = DEF_DATA_W + DEF_PROB_W + 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     load,
    input  logic                     accum,
    input  logic                     capture,
    input  logic signed [DATA_W-1:0] v,
    input  logic        [PROB_W-1:0] p,
    output logic        [DATA_W-1:0] res,
    output logic                     sat
);

    localparam logic signed [ACC_W-1:0] RND = ACC_W'(round_bias(PROB_W));

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  prod;
    logic signed [ACC_W-1:0]  final_sum;
    logic        [DATA_W-1:0] res_nxt;
    logic                     sat_nxt;

    // Probability is zero-extended so the multiply stays signed.
    assign prod      = ACC_W'(v) * ACC_W'($signed({1'b0, p}));
    assign final_sum = load ? prod : acc + prod;

`ifdef ATTN_WSUM_SAT_EN
    localparam int unsigned RES_W = ACC_W - PROB_W;

    logic signed [RES_W-1:0] r;
    logic signed [63:0]      r_ext;
    logic signed [63:0]      clamped;

    // Round, then clamp into the output range and flag any clamping.
    always_comb begin
        r       = RES_W'((final_sum + RND) >>> PROB_W);
        r_ext   = 64'(r);
        clamped = saturate(r_ext, DATA_W);
        res_nxt = DATA_W'(clamped);
        sat_nxt = (clamped != r_ext);
    end

    // Saturation indicator captured alongside the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat <= 1'b0;
        end else if (capture) begin
            sat <= sat_nxt;
        end
    end
`else
    // Round, then keep the low DATA_W bits (wrap).
    always_comb begin
        res_nxt = DATA_W'((final_sum + RND) >>> PROB_W);
        sat_nxt = 1'b0;
    end

    assign sat = sat_nxt;
`endif

    // Accumulator: clear after handoff, load on first key, add afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (load) begin
            acc <= prod;
        end else if (accum) begin
            acc <= final_sum;
        end
    end

    // Result register, loaded from the final sum on the terminating beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
        end else if (capture) begin
            res <= res_nxt;
        end
    end

endmodule

// File: rtl/attn_weighted_sum.sv
// Attention weighted sum: out[d] = sum_k p_k * v_k[d] over one head,
// rounded from Q0.PROB_W scaling and reduced to DATA_W per lane.
// Holds the head FSM, beat counter, valid/ready handshakes and flags.
// Config: define ATTN_WSUM_SAT_EN for saturating lanes with sat_flag;
// default build wraps and keeps sat_flag low.
module attn_weighted_sum
    import attn_pkg::*;
#(
    parameter int unsigned DIM     = 4,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned PROB_W  = DEF_PROB_W,
    parameter int unsigned SEQ_LEN = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PROB_W-1:0]     in_prob,
    input  logic [DIM*DATA_W-1:0] in_v,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIM*DATA_W-1:0] out_data,
    output logic                  sat_flag,
    output logic                  len_err
);

    localparam int unsigned ACC_W = DATA_W + PROB_W + $clog2(SEQ_LEN) + 1;
    localparam int unsigned CNT_W = $clog2(SEQ_LEN) + 1;

    wsum_state_t      state;
    wsum_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             term_hit;
    logic             lane_clear;
    logic             lane_load;
    logic             lane_accum;
    logic             lane_capture;
    logic [DIM-1:0]   lane_sat;

    assign cnt_inc   = cnt + CNT_W'(1);
    assign term_hit  = in_last || (cnt_inc == CNT_W'(SEQ_LEN));
    assign out_valid = (state == OUTPUT);
    assign sat_flag  = |lane_sat;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and lane controls from the handshake inputs.
    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        lane_clear   = 1'b0;
        lane_load    = 1'b0;
        lane_accum   = 1'b0;
        lane_capture = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    lane_load = 1'b1;
                    if (term_hit) begin
                        lane_capture = 1'b1;
                        state_nxt    = OUTPUT;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    lane_accum = 1'b1;
                    if (term_hit) begin
                        lane_capture = 1'b1;
                        state_nxt    = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    lane_clear = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Beats accepted in the current head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (lane_clear) begin
            cnt <= '0;
        end else if (lane_load) begin
            cnt <= CNT_W'(1);
        end else if (lane_accum) begin
            cnt <= cnt_inc;
        end
    end

    // Length error pulses with out_valid when the head ran out of slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_err <= 1'b0;
        end else begin
            len_err <= lane_capture && !in_last;
        end
    end

    for (genvar d = 0; d < DIM; d++) begin : g_lane
        wsum_lane #(
            .DATA_W (DATA_W),
            .PROB_W (PROB_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (lane_clear),
            .load    (lane_load),
            .accum   (lane_accum),
            .capture (lane_capture),
            .v       (in_v[d*DATA_W +: DATA_W]),
            .p       (in_prob),
            .res     (out_data[d*DATA_W +: DATA_W]),
            .sat     (lane_sat[d])
        );
    end

endmodule

// File: tb/tb_attn_weighted_sum.sv
// Randomized bench for attn_weighted_sum with a behavioural reference model.
`timescale 1ns/1ps
module tb_attn_weighted_sum;

    localparam int DIM     = 4;
    localparam int DATA_W  = 16;
    localparam int PROB_W  = 16;
    localparam int SEQ_LEN = 128;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [PROB_W-1:0]     in_prob = '0;
    logic [DIM*DATA_W-1:0] in_v = '0;
    logic                  in_last = 1'b0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [DIM*DATA_W-1:0] out_data;
    logic                  sat_flag;
    logic                  len_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PROB_W-1:0]     hp[$];
    logic [DIM*DATA_W-1:0] hv[$];
    longint                exp_lane[DIM];
    logic                  exp_sat;

    attn_weighted_sum #(
        .DIM     (DIM),
        .DATA_W  (DATA_W),
        .PROB_W  (PROB_W),
        .SEQ_LEN (SEQ_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prob   (in_prob),
        .in_v      (in_v),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_flag  (sat_flag),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DIM*DATA_W-1:0] make_row(input int a, input int b,
                                                       input int c, input int e);
        logic [DIM*DATA_W-1:0] row;
        int vals[DIM];
        vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = e;
        for (int d = 0; d < DIM; d++) row[d*DATA_W +: DATA_W] = DATA_W'(vals[d]);
        return row;
    endfunction

    function automatic longint lane_of(input logic [DIM*DATA_W-1:0] row, input int d);
        logic signed [DATA_W-1:0] x;
        x = row[d*DATA_W +: DATA_W];
        return longint'(x);
    endfunction

    // Reference: exact dot product per lane, round half up, then reduce.
    task automatic compute_expected(input int nb);
        exp_sat = 1'b0;
        for (int d = 0; d < DIM; d++) begin
            longint s;
            longint r;
            longint hi;
            longint lo;
            s = 0;
            for (int k = 0; k < nb; k++) s += lane_of(hv[k], d) * longint'(hp[k]);
            r  = (s + (longint'(1) <<< (PROB_W - 1))) >>> PROB_W;
            hi = (longint'(1) <<< (DATA_W - 1)) - 1;
            lo = -(longint'(1) <<< (DATA_W - 1));
`ifdef ATTN_WSUM_SAT_EN
            if (r > hi) begin
                r = hi;
                exp_sat = 1'b1;
            end else if (r < lo) begin
                r = lo;
                exp_sat = 1'b1;
            end
`else
            r = r & ((longint'(1) <<< DATA_W) - 1);
            if (r > hi) r -= (longint'(1) <<< DATA_W);
`endif
            exp_lane[d] = r;
        end
    endtask

    task automatic compare_outputs(input string tag);
        for (int d = 0; d < DIM; d++)
            check($sformatf("%s_lane%0d", tag, d), lane_of(out_data, d), exp_lane[d]);
        check({tag, "_sat"}, sat_flag, exp_sat);
    endtask

    // Drive the queued head, then check result, hold for `hold` cycles, release.
    task automatic run_head(input string tag, input int hold, input bit use_last,
                            input bit gaps);
        int nb;
        int guard;
        nb = hp.size();
        compute_expected(nb);
        for (int k = 0; k < nb; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
            end
            in_valid = 1'b1;
            in_prob  = hp[k];
            in_v     = hv[k];
            in_last  = use_last && (k == nb - 1);
            guard = 0;
            while (!in_ready && guard < 20) begin
                tick();
                guard++;
            end
            if (guard == 20) check({tag, "_in_ready_wait"}, in_ready, 1);
            if (k == nb - 1) check({tag, "_no_early_valid"}, out_valid, 0);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, "_valid_lat1"}, out_valid, 1);
        check({tag, "_len_err"}, len_err, !use_last);
        compare_outputs(tag);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_prob  = PROB_W'($urandom);
            in_v     = {$urandom, $urandom};
            in_last  = 1'($urandom);
            tick();
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_in_ready"}, in_ready, 0);
            check({tag, "_hold_len_err"}, len_err, 0);
            compare_outputs({tag, "_hold"});
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_release_valid"}, out_valid, 0);
        check({tag, "_release_in_ready"}, in_ready, 1);
        hp.delete();
        hv.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_len_err", len_err, 0);
        check("rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        hp.push_back(16'h8000); hv.push_back(make_row(100, -100, 0, 7));
        run_head("single", 0, 1'b1, 1'b0);

        hp.push_back(16'h8000); hv.push_back(make_row(200, 200, 200, 200));
        hp.push_back(16'h8000); hv.push_back(make_row(100, 100, 100, 100));
        run_head("two_beat", 2, 1'b1, 1'b0);

        hp.push_back(16'h8000); hv.push_back(make_row(100, 100, 100, 100));
        run_head("fresh_head", 0, 1'b1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            hp.push_back(16'hFFFF); hv.push_back(make_row(32767, 32767, 32767, 32767));
        end
        run_head("sat", 1, 1'b1, 1'b0);

        for (int k = 0; k < 3; k++) begin
            hp.push_back(PROB_W'($urandom_range(0, 16'h4000)));
            hv.push_back({$urandom, $urandom});
        end
        run_head("backpressure", 5, 1'b1, 1'b1);

        for (int k = 0; k < SEQ_LEN; k++) begin
            hp.push_back(16'h0100); hv.push_back(make_row(1, 1, 1, 1));
        end
        run_head("overflow", 1, 1'b0, 1'b0);

        // Reset in the middle of a head; partial sum must not leak.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_prob  = 16'hFFFF;
            in_v     = make_row(1000, -1000, 500, 300);
            in_last  = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_sat", sat_flag, 0);
        check("midrst_len_err", len_err, 0);
        check("midrst_in_ready", in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        hp.push_back(16'h8000); hv.push_back(make_row(10, 10, 10, 10));
        run_head("after_rst", 0, 1'b1, 1'b0);

        for (int t = 0; t < 25; t++) begin
            int nb;
            nb = $urandom_range(1, 12);
            for (int k = 0; k < nb; k++) begin
                hp.push_back(PROB_W'($urandom));
                hv.push_back({$urandom, $urandom});
            end
            run_head($sformatf("rand%0d", t), $urandom_range(0, 3), 1'b1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/attn_weighted_sum.md
Name: attn_weighted_sum

Overview:
- Downstream of the softmax stage. Consumes one attention head's probabilities, one per key, paired with that key's value row.
- Accumulates out[d] = sum_k p_k * v_k[d] across all keys, for DIM lanes in parallel.
- Emits one rounded, width-reduced output vector per head via a valid/ready handshake.
- Output feeds the head-concat / output-projection stage.

Parameters:
- DIM, 4: value-vector lanes processed in parallel.
- DATA_W, 16: signed two's-complement width of each value lane and each output lane (Q8.8).
- PROB_W, 16: unsigned probability width, pure fraction Q0.PROB_W (0xFFFF ~ 1.0).
- SEQ_LEN, 128: maximum keys per head.
- ACC_W (localparam): DATA_W+PROB_W+$clog2(SEQ_LEN)+1, accumulator width per lane.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  beat valid
- in_ready  output  1  block can accept a beat
- in_prob  input  PROB_W  probability p_k, unsigned
- in_v  input  DIM*DATA_W  value row, lane d at bits [d*DATA_W +: DATA_W], signed
- in_last  input  1  final key of the head
- out_valid  output  1  result vector valid
- out_ready  input  1  consumer accepts the result
- out_data  output  DIM*DATA_W  result vector, same packing as in_v
- sat_flag  output  1  at least one lane saturated in the current result (valid with out_valid)
- len_err  output  1  one-cycle pulse: SEQ_LEN beats received without in_last

Behaviour:
- Reset (async, asserted anywhere, including mid-head):
  - state=IDLE; all accumulators 0; beat counter 0.
  - out_valid=0, out_data=0, sat_flag=0, len_err=0.
  - Partial head discarded.
- States: IDLE, ACCUM, OUTPUT.
  - in_ready=1 in IDLE and ACCUM; in_ready=0 in OUTPUT.
- Beat accepted when in_valid && in_ready.
- Per-lane product: signed(v)*{1'b0,p}, sign-extended to ACC_W.
- IDLE + beat: acc <= product (no stale sum); cnt <= 1; go to ACCUM, unless the terminate condition holds.
- ACCUM + beat: acc <= acc + product; cnt <= cnt+1.
- Terminate condition: in_last, or cnt+1 == SEQ_LEN.
  - Applies in IDLE and ACCUM.
  - On the accepting edge, register out_data from the final sum (acc+product) and go to OUTPUT.
  - out_valid=1 on the next cycle: latency 1 cycle after the last beat.
- len_err: pulses 1 cycle, coincident with out_valid rising, when termination came from cnt reaching SEQ_LEN without in_last.
- Result per lane: r = (sum + 2^(PROB_W-1)) >>> PROB_W, arithmetic shift, round half toward +inf. Then width reduction (see Optional Feature).
- OUTPUT:
  - out_valid, out_data and sat_flag held stable until out_ready.
  - On out_valid && out_ready: out_valid<=0, acc<=0, cnt<=0, state=IDLE.
  - in_ready stays 0 during that handshake cycle; the next head's first beat is accepted the cycle after.
- in_valid with in_ready=0: ignored. Upstream must hold the beat.
- Idle cycles (in_valid=0) in ACCUM: accumulators hold.

Optional Feature:
- Macro ATTN_WSUM_SAT_EN.
- Defined: each lane r is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; sat_flag=1 if any lane clamped.
- Undefined: r truncated to its low DATA_W bits (wrap); sat_flag tied 0.

Decomposition:
- Shared package attn_pkg holds:
  - state enum typedef (IDLE/ACCUM/OUTPUT);
  - default DATA_W/PROB_W constants;
  - rounding-constant function;
  - saturate function.
- Sub-module wsum_lane, instantiated DIM times:
  - one signed×unsigned MAC with clear/load/accumulate controls;
  - round/reduce output.
- Top holds the FSM, beat counter, handshake and flag logic.

Test Plan:
- Single beat: p=0x8000, v={100,-100,0,7}, in_last=1 -> out_data={50,-50,0,4}, out_valid exactly 1 cycle later, len_err=0.
- Two beats: p=0x8000 with v=200, then p=0x8000 with v=100 (all lanes), in_last on the 2nd -> all lanes 150; next head's first beat clears acc (lanes 50 for a single beat p=0x8000, v=100).
- Saturation, macro on: 4 beats p=0xFFFF, v=32767, last on the 4th -> lanes 32767, sat_flag=1. Macro off: the same stimulus yields the wrapped value, sat_flag=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, out_data, sat_flag stable; in_ready=0 throughout; in_valid beats ignored; release -> IDLE, in_ready=1 the next cycle.
- Length overflow: 128 beats p=0x0100, v=1, no in_last -> out_valid after the 128th beat, lanes (128*256+32768)>>16 = 1, len_err one-cycle pulse.
- Reset mid-head: 3 beats accepted, rst_n low 2 cycles -> all outputs 0, state IDLE; next head of 1 beat p=0x8000, v=10 -> 5 (no residue).
